// File: rtl/sha256_pkg.sv
// Shared constants and FSM state type for the SHA-256 message padding stage.
package sha256_pkg;

  localparam int BLOCK_W    = 512;
  localparam int LEN_W      = 64;
  localparam int ID_W       = 6;
  localparam int PAD_THRESH = 448;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    EXTRA = 2'd2
  } state_e;

  // Bit offset of the message end inside its final block.
  function automatic logic [8:0] tail_bits(input logic [LEN_W-1:0] len);
    return len[8:0];
  endfunction

endpackage

// File: rtl/sha256_pad_block.sv
// Combinational SHA-2 padding of one message block: end marker, zero fill and
// length field, plus a flag telling the caller a further block must follow.
module sha256_pad_block
  import sha256_pkg::*;
(
  input  logic [BLOCK_W-1:0] block_i,
  input  logic [8:0]         r_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               is_last_i,
  output logic [BLOCK_W-1:0] padded_o,
  output logic               needs_extra_o
);

  logic [BLOCK_W-1:0] marker_s;
  logic [BLOCK_W-1:0] keep_mask_s;

  // Marker lands just after the last message bit; the mask keeps only message bits.
  assign marker_s    = {1'b1, {(BLOCK_W-1){1'b0}}} >> r_i;
  assign keep_mask_s = ~({BLOCK_W{1'b1}} >> r_i);

  // Select the padded form of the block.
  always_comb begin
    padded_o      = block_i;
    needs_extra_o = 1'b0;
    if (is_last_i) begin
      if (len_i == {LEN_W{1'b0}}) begin
        padded_o = {1'b1, {(BLOCK_W-1){1'b0}}};
      end else if (r_i == 9'd0) begin
        needs_extra_o = 1'b1;
      end else begin
        padded_o = (block_i & keep_mask_s) | marker_s;
        if (r_i < 9'(PAD_THRESH)) begin
          padded_o[LEN_W-1:0] = len_i;
        end else begin
          needs_extra_o = 1'b1;
        end
      end
    end else begin
      padded_o      = block_i;
      needs_extra_o = 1'b0;
    end
  end

endmodule

// File: rtl/sha256_message_build.sv
// SHA-256 message builder: takes one config beat and the raw blocks of a message,
// emits padded blocks (with an extra block when needed) tagged with the message id.
module sha256_message_build
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               nrst,
  input  logic               en,
  input  logic               sync_rst,
  input  logic [LEN_W-1:0]   cfg_size,
  input  logic [1:0]         cfg_scheme,
  input  logic [ID_W-1:0]    cfg_id,
  input  logic               cfg_last,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [BLOCK_W-1:0] data_in,
  input  logic               data_in_last,
  input  logic               data_in_valid,
  output logic               data_in_ready,
  output logic [BLOCK_W-1:0] data_out,
  output logic [ID_W-1:0]    data_out_id,
  output logic               data_out_last,
  output logic               data_out_valid,
  input  logic               data_out_ready
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   size_q, size_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [BLOCK_W-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]    out_id_q, out_id_d;
  logic               out_last_q, out_last_d;
  logic               out_valid_q, out_valid_d;

  logic               slot_free_s;
  logic [BLOCK_W-1:0] padded_s;
  logic               needs_extra_s;
  logic [BLOCK_W-1:0] extra_s;
  logic               unused_cfg_s;

  assign unused_cfg_s = ^{cfg_scheme, cfg_last};

  assign slot_free_s   = ~out_valid_q | data_out_ready;
  assign cfg_ready     = en & (state_q == IDLE);
  assign data_in_ready = en & (state_q == DATA) & slot_free_s;

  // Marker only goes in the extra block when the message filled its last block exactly.
  assign extra_s = {(tail_bits(size_q) == 9'd0), {(BLOCK_W-LEN_W-1){1'b0}}, size_q};

  sha256_pad_block u_pad (
    .block_i       (data_in),
    .r_i           (tail_bits(size_q)),
    .len_i         (size_q),
    .is_last_i     (data_in_last),
    .padded_o      (padded_s),
    .needs_extra_o (needs_extra_s)
  );

  // Next-state and output-register load logic.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    id_d        = id_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (en) begin
      if (out_valid_q && data_out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            size_d  = cfg_size;
            id_d    = cfg_id;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          if (data_in_valid && slot_free_s) begin
            out_data_d  = padded_s;
            out_id_d    = id_q;
            out_last_d  = data_in_last & ~needs_extra_s;
            out_valid_d = 1'b1;
            if (data_in_last) begin
              state_d = needs_extra_s ? EXTRA : IDLE;
            end else begin
              state_d = DATA;
            end
          end else begin
            state_d = DATA;
          end
        end
        EXTRA: begin
          if (slot_free_s) begin
            out_data_d  = extra_s;
            out_id_d    = id_q;
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = EXTRA;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      out_valid_d = out_valid_q;
      state_d     = state_q;
    end
  end

  // State and output registers with async and synchronous reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      size_q      <= {LEN_W{1'b0}};
      id_q        <= {ID_W{1'b0}};
      out_data_q  <= {BLOCK_W{1'b0}};
      out_id_q    <= {ID_W{1'b0}};
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (sync_rst) begin
      state_q     <= IDLE;
      size_q      <= {LEN_W{1'b0}};
      id_q        <= {ID_W{1'b0}};
      out_data_q  <= {BLOCK_W{1'b0}};
      out_id_q    <= {ID_W{1'b0}};
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      id_q        <= id_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign data_out       = out_data_q;
  assign data_out_id    = out_id_q;
  assign data_out_last  = out_last_q;
  assign data_out_valid = out_valid_q;

endmodule
